// File: rtl/rv32i_trap_seq.sv
// Machine-mode trap/MRET sequencer: owns the single CSR-file access port, arbitrating
// between pipeline CSR instructions and the multi-cycle trap-entry and MRET sequences.
module rv32i_trap_seq #(
  parameter int unsigned VECTORED_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_csr_req,
  input  logic [11:0] pipe_csr_addr,
  input  logic [31:0] pipe_csr_wdata,
  input  logic [2:0]  pipe_csr_op,
  input  logic        pipe_csr_we,
  output logic        pipe_csr_gnt,
  output logic [31:0] pipe_csr_rdata,
  output logic        pipe_csr_illegal,
  input  logic        trap_req,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  output logic        trap_ack,
  input  logic        mret_req,
  output logic        mret_ack,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  output logic [2:0]  csr_op,
  output logic        csr_we,
  input  logic [31:0] csr_rdata,
  input  logic        csr_illegal,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [2:0]  OP_RW       = 3'b001;
  localparam logic [2:0]  OP_RS       = 3'b010;

  typedef enum logic [3:0] {
    IDLE,
    T_TVEC,
    T_EPC,
    T_CAUSE,
    T_TVAL,
    T_SREAD,
    T_SWRITE,
    T_DONE,
    M_STAT,
    M_SWR,
    M_EPC,
    M_DONE
  } state_t;

  state_t      state_reg;
  logic [31:0] cause_reg;
  logic [31:0] pc_reg;
  logic [31:0] tval_reg;
  logic [31:0] target_reg;
  logic [31:0] mstatus_reg;

  logic [31:0] tvec_base;
  logic        tvec_vectored;
  logic [31:0] tvec_target;
  logic [31:0] trap_mstatus;
  logic [31:0] mret_mstatus;

  assign busy = (state_reg != IDLE);

  // Vector offset only for interrupts when MTVEC mode is 01; the add wraps at 32 bits.
  assign tvec_base     = {csr_rdata[31:2], 2'b00};
  assign tvec_vectored = (VECTORED_EN != 0) && (csr_rdata[1:0] == 2'b01) && cause_reg[31];
  assign tvec_target   = tvec_vectored ? (tvec_base + {25'd0, cause_reg[4:0], 2'b00}) : tvec_base;

  // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M.  MRET: MIE <= MPIE, MPIE <= 1, MPP <= M.
  assign trap_mstatus = {mstatus_reg[31:13], 2'b11, mstatus_reg[10:8], mstatus_reg[3],
                         mstatus_reg[6:4], 1'b0, mstatus_reg[2:0]};
  assign mret_mstatus = {mstatus_reg[31:13], 2'b11, mstatus_reg[10:8], 1'b1,
                         mstatus_reg[6:4], mstatus_reg[7], mstatus_reg[2:0]};

  always_comb begin
    csr_addr         = 12'h000;
    csr_wdata        = 32'h0;
    csr_op           = OP_RS;
    csr_we           = 1'b0;
    pipe_csr_gnt     = 1'b0;
    pipe_csr_rdata   = 32'h0;
    pipe_csr_illegal = 1'b0;
    case (state_reg)
      IDLE: begin
        csr_addr     = pipe_csr_addr;
        csr_wdata    = pipe_csr_wdata;
        csr_op       = pipe_csr_op;
        pipe_csr_gnt = pipe_csr_req & ~trap_req & ~mret_req;
        if (pipe_csr_gnt) begin
          csr_we           = pipe_csr_we;
          pipe_csr_rdata   = csr_rdata;
          pipe_csr_illegal = csr_illegal;
        end
      end
      T_TVEC:  csr_addr = CSR_MTVEC;
      T_EPC: begin
        csr_addr  = CSR_MEPC;
        csr_wdata = {pc_reg[31:2], 2'b00};
        csr_op    = OP_RW;
        csr_we    = 1'b1;
      end
      T_CAUSE: begin
        csr_addr  = CSR_MCAUSE;
        csr_wdata = cause_reg;
        csr_op    = OP_RW;
        csr_we    = 1'b1;
      end
      T_TVAL: begin
        csr_addr  = CSR_MTVAL;
        csr_wdata = tval_reg;
        csr_op    = OP_RW;
        csr_we    = 1'b1;
      end
      T_SREAD: csr_addr = CSR_MSTATUS;
      T_SWRITE: begin
        csr_addr  = CSR_MSTATUS;
        csr_wdata = trap_mstatus;
        csr_op    = OP_RW;
        csr_we    = 1'b1;
      end
      M_STAT:  csr_addr = CSR_MSTATUS;
      M_SWR: begin
        csr_addr  = CSR_MSTATUS;
        csr_wdata = mret_mstatus;
        csr_op    = OP_RW;
        csr_we    = 1'b1;
      end
      M_EPC:   csr_addr = CSR_MEPC;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cause_reg      <= 32'h0;
      pc_reg         <= 32'h0;
      tval_reg       <= 32'h0;
      target_reg     <= 32'h0;
      mstatus_reg    <= 32'h0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'h0;
      trap_ack       <= 1'b0;
      mret_ack       <= 1'b0;
    end else begin
      redirect_valid <= 1'b0;
      trap_ack       <= 1'b0;
      mret_ack       <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (trap_req) begin
            cause_reg <= trap_cause;
            pc_reg    <= trap_pc;
            tval_reg  <= trap_tval;
            state_reg <= T_TVEC;
          end else if (mret_req) begin
            state_reg <= M_STAT;
          end
        end
        T_TVEC: begin
          target_reg <= tvec_target;
          state_reg  <= T_EPC;
        end
        T_EPC:   state_reg <= T_CAUSE;
        T_CAUSE: state_reg <= T_TVAL;
        T_TVAL:  state_reg <= T_SREAD;
        T_SREAD: begin
          mstatus_reg <= csr_rdata;
          state_reg   <= T_SWRITE;
        end
        T_SWRITE: begin
          redirect_valid <= 1'b1;
          redirect_pc    <= target_reg;
          trap_ack       <= 1'b1;
          state_reg      <= T_DONE;
        end
        T_DONE:  state_reg <= IDLE;
        M_STAT: begin
          mstatus_reg <= csr_rdata;
          state_reg   <= M_SWR;
        end
        M_SWR:   state_reg <= M_EPC;
        M_EPC: begin
          target_reg     <= csr_rdata;
          redirect_valid <= 1'b1;
          redirect_pc    <= csr_rdata;
          mret_ack       <= 1'b1;
          state_reg      <= M_DONE;
        end
        M_DONE:  state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_trap_seq.sv
// Bench for rv32i_trap_seq: two instances (vectored and flat) share stimulus, each backed
// by a small behavioural CSR file; results are checked against a spec-level shadow model.
module tb_rv32i_trap_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        env_clr;
  logic        pipe_csr_req;
  logic [11:0] pipe_csr_addr;
  logic [31:0] pipe_csr_wdata;
  logic [2:0]  pipe_csr_op;
  logic        pipe_csr_we;
  logic        trap_req;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_tval;
  logic        mret_req;

  logic        v_gnt, f_gnt, v_pill, f_pill, v_tack, f_tack, v_mack, f_mack;
  logic        v_cwe, f_cwe, v_cill, f_cill, v_rv, f_rv, v_busy, f_busy;
  logic [31:0] v_prdata, f_prdata, v_cwdata, f_cwdata, v_crdata, f_crdata, v_rpc, f_rpc;
  logic [11:0] v_caddr, f_caddr;
  logic [2:0]  v_cop, f_cop;

  always #5 clk = ~clk;

  rv32i_trap_seq #(.VECTORED_EN(1)) u_vec (
    .clk(clk), .rst(rst),
    .pipe_csr_req(pipe_csr_req), .pipe_csr_addr(pipe_csr_addr), .pipe_csr_wdata(pipe_csr_wdata),
    .pipe_csr_op(pipe_csr_op), .pipe_csr_we(pipe_csr_we), .pipe_csr_gnt(v_gnt),
    .pipe_csr_rdata(v_prdata), .pipe_csr_illegal(v_pill),
    .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
    .trap_ack(v_tack), .mret_req(mret_req), .mret_ack(v_mack),
    .csr_addr(v_caddr), .csr_wdata(v_cwdata), .csr_op(v_cop), .csr_we(v_cwe),
    .csr_rdata(v_crdata), .csr_illegal(v_cill),
    .redirect_valid(v_rv), .redirect_pc(v_rpc), .busy(v_busy)
  );

  rv32i_trap_seq #(.VECTORED_EN(0)) u_flat (
    .clk(clk), .rst(rst),
    .pipe_csr_req(pipe_csr_req), .pipe_csr_addr(pipe_csr_addr), .pipe_csr_wdata(pipe_csr_wdata),
    .pipe_csr_op(pipe_csr_op), .pipe_csr_we(pipe_csr_we), .pipe_csr_gnt(f_gnt),
    .pipe_csr_rdata(f_prdata), .pipe_csr_illegal(f_pill),
    .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
    .trap_ack(f_tack), .mret_req(mret_req), .mret_ack(f_mack),
    .csr_addr(f_caddr), .csr_wdata(f_cwdata), .csr_op(f_cop), .csr_we(f_cwe),
    .csr_rdata(f_crdata), .csr_illegal(f_cill),
    .redirect_valid(f_rv), .redirect_pc(f_rpc), .busy(f_busy)
  );

  // ---------------- behavioural CSR files ----------------
  function automatic int cidx(input logic [11:0] a);
    case (a)
      12'h300: return 0;
      12'h304: return 1;
      12'h305: return 2;
      12'h340: return 3;
      12'h341: return 4;
      12'h342: return 5;
      12'h343: return 6;
      12'h344: return 7;
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] csr_apply(input logic [2:0] op, input logic [31:0] old,
                                            input logic [31:0] wd);
    case (op[1:0])
      2'b01:   return wd;
      2'b10:   return old | wd;
      2'b11:   return old & ~wd;
      default: return old;
    endcase
  endfunction

  logic [31:0] csr_v [8];
  logic [31:0] csr_f [8];
  int          v_idx, f_idx;

  always_comb begin
    v_idx    = cidx(v_caddr);
    f_idx    = cidx(f_caddr);
    v_crdata = (v_idx >= 0) ? csr_v[v_idx[2:0]] : 32'h0;
    f_crdata = (f_idx >= 0) ? csr_f[f_idx[2:0]] : 32'h0;
    v_cill   = (v_idx < 0);
    f_cill   = (f_idx < 0);
  end

  always @(posedge clk) begin
    if (env_clr) begin
      for (int i = 0; i < 8; i++) begin
        csr_v[i] <= 32'h0;
        csr_f[i] <= 32'h0;
      end
    end else begin
      if (v_cwe && v_idx >= 0) csr_v[v_idx[2:0]] <= csr_apply(v_cop, csr_v[v_idx[2:0]], v_cwdata);
      if (f_cwe && f_idx >= 0) csr_f[f_idx[2:0]] <= csr_apply(f_cop, csr_f[f_idx[2:0]], f_cwdata);
    end
  end

  // ---------------- spec-level reference model ----------------
  logic [31:0] shadow [8];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] m_target(input logic [31:0] mtvec, input logic [31:0] cause,
                                           input bit vec);
    logic [31:0] base = mtvec & 32'hFFFF_FFFC;
    if (vec && (mtvec & 32'h3) == 32'h1 && cause >= 32'h8000_0000)
      return base + (cause & 32'h1F) * 32'd4;
    return base;
  endfunction

  function automatic logic [31:0] m_trap_ms(input logic [31:0] s);
    return (s & ~32'h88) | 32'h1800 | (((s & 32'h8) != 0) ? 32'h80 : 32'h0);
  endfunction

  function automatic logic [31:0] m_mret_ms(input logic [31:0] s);
    return (s & ~32'h8) | 32'h1880 | (((s & 32'h80) != 0) ? 32'h8 : 32'h0);
  endfunction

  typedef struct {
    bit          is_mret;
    logic [31:0] tvec_or_epc, mstatus, cause, pc, tval;
    logic [31:0] exp_pc_v, exp_pc_nv, exp_mstatus, exp_epc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic pipe_op(input logic [11:0] a, input logic [31:0] wd, input logic [2:0] op,
                         input logic we, output logic [31:0] rd, output logic ill);
    bit got = 0;
    rd = 32'h0;
    ill = 1'b0;
    pipe_csr_req = 1'b1; pipe_csr_addr = a; pipe_csr_wdata = wd;
    pipe_csr_op = op;    pipe_csr_we = we;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (v_gnt) begin
        rd  = v_prdata;
        ill = v_pill;
        got = 1;
        break;
      end
      @(negedge clk);
    end
    if (!got) check("pipe_gnt_timeout", 32'(v_gnt), 32'h1);
    @(negedge clk);
    pipe_csr_req = 1'b0;
  endtask

  task automatic pipe_rw(input logic [11:0] a, input logic [31:0] val, input string name);
    logic [31:0] rd;
    logic ill;
    int i = cidx(a);
    pipe_op(a, val, 3'b001, 1'b1, rd, ill);
    if (i >= 0) begin
      check({name, "_old"}, rd, shadow[i]);
      shadow[i] = val;
    end
  endtask

  task automatic do_seq(input vec_t v, input string name);
    int cyc = 0;
    int lat = v.is_mret ? 4 : 7;
    if (v.is_mret) mret_req = 1'b1;
    else begin
      trap_cause = v.cause; trap_pc = v.pc; trap_tval = v.tval; trap_req = 1'b1;
    end
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (v_rv) begin
        cyc = c;
        break;
      end
    end
    check({name, "_lat"}, cyc, lat);
    if (cyc != 0) begin
      check({name, "_pc_vec"}, v_rpc, v.exp_pc_v);
      check({name, "_pc_flat"}, f_rpc, v.exp_pc_nv);
      check({name, "_ack"}, v.is_mret ? 32'(v_mack) : 32'(v_tack), 32'h1);
      check({name, "_other_ack"}, v.is_mret ? 32'(v_tack) : 32'(v_mack), 32'h0);
    end
    trap_req = 1'b0;
    mret_req = 1'b0;
    @(negedge clk);
    check({name, "_idle"}, {30'd0, v_busy, v_rv}, 32'h0);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    if (v.is_mret) begin
      pipe_rw(12'h341, v.tvec_or_epc, {name, "_set_mepc"});
      pipe_rw(12'h300, v.mstatus, {name, "_set_ms"});
      do_seq(v, name);
    end else begin
      pipe_rw(12'h305, v.tvec_or_epc, {name, "_set_mtvec"});
      pipe_rw(12'h300, v.mstatus, {name, "_set_ms"});
      do_seq(v, name);
      shadow[4] = v.exp_epc;
      shadow[5] = v.cause;
      shadow[6] = v.tval;
    end
    shadow[0] = v.exp_mstatus;
    for (int i = 0; i < 8; i++) check($sformatf("%s_csr%0d", name, i), csr_v[i], shadow[i]);
    check({name, "_flat_ms"}, csr_f[0], shadow[0]);
  endtask

  vec_t tbl [8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, r;
    logic ill;
    logic [2:0] ops [6] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
    logic [11:0] addrs [10] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                                12'h342, 12'h343, 12'h344, 12'h7C0, 12'hF11};
    vec_t v;
    int cyc_t, cyc_m, cyc_g, idx;

    tbl[0] = '{0, 32'h100, 32'h1808, 32'h2, 32'h80, 32'hDEADBEEF,
               32'h100, 32'h100, 32'h1880, 32'h80};
    tbl[1] = '{0, 32'h101, 32'h1808, 32'h8000_0007, 32'h200, 32'h0,
               32'h11C, 32'h100, 32'h1880, 32'h200};
    tbl[2] = '{1, 32'h84, 32'h1880, 0, 0, 0, 32'h84, 32'h84, 32'h1888, 32'h84};
    tbl[3] = '{0, 32'hFFFF_FFFD, 32'h0, 32'h8000_001F, 32'h1237, 32'h55,
               32'h78, 32'hFFFF_FFFC, 32'h1800, 32'h1234};
    tbl[4] = '{0, 32'h103, 32'h8, 32'h8000_0003, 32'h40, 32'h1,
               32'h100, 32'h100, 32'h1880, 32'h40};
    tbl[5] = '{0, 32'h101, 32'hFFFF_FFFF, 32'h5, 32'h8, 32'h2,
               32'h100, 32'h100, 32'hFFFF_FFF7, 32'h8};
    tbl[6] = '{1, 32'h1000, 32'h0, 0, 0, 0, 32'h1000, 32'h1000, 32'h1880, 32'h1000};
    tbl[7] = '{1, 32'hDEAD0000, 32'hFFFF_FFFF, 0, 0, 0,
               32'hDEAD0000, 32'hDEAD0000, 32'hFFFF_FFFF, 32'hDEAD0000};

    rst = 1'b1; env_clr = 1'b1;
    pipe_csr_req = 0; pipe_csr_addr = 0; pipe_csr_wdata = 0; pipe_csr_op = 0; pipe_csr_we = 0;
    trap_req = 0; trap_cause = 0; trap_pc = 0; trap_tval = 0; mret_req = 0;
    for (int i = 0; i < 8; i++) shadow[i] = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(v_busy), 32'h0);
    check("reset_redirect", {29'd0, v_rv, v_tack, v_mack}, 32'h0);
    check("reset_redirect_pc", v_rpc, 32'h0);
    rst = 1'b0; env_clr = 1'b0;
    @(negedge clk);

    // Table-driven trap / MRET vectors
    for (int k = 0; k < 8; k++) run_vec(tbl[k], $sformatf("vec%0d", k));

    // Pipe CSR accesses
    pipe_rw(12'h340, 32'h5A5A5A5A, "pipe_rw_mscratch");
    pipe_op(12'h340, 32'h0, 3'b010, 1'b0, rd, ill);
    check("pipe_rs_rdata", rd, 32'h5A5A5A5A);
    check("pipe_rs_illegal", 32'(ill), 32'h0);
    pipe_op(12'h7C0, 32'h0, 3'b010, 1'b0, rd, ill);
    check("pipe_illegal_7c0", 32'(ill), 32'h1);
    pipe_op(12'h340, 32'h0F0F0F0F, 3'b011, 1'b1, rd, ill);
    check("pipe_rc_rdata", rd, 32'h5A5A5A5A);
    check("pipe_rc_result", csr_v[3], 32'h50505050);
    pipe_op(12'h340, 32'h3, 3'b110, 1'b1, rd, ill);
    check("pipe_rsi_result", csr_v[3], 32'h50505053);
    shadow[3] = 32'h50505053;

    // Simultaneous trap, MRET and pipe requests
    pipe_rw(12'h305, 32'h100, "race_mtvec");
    pipe_rw(12'h300, 32'h1808, "race_ms");
    cyc_t = 0; cyc_m = 0; cyc_g = 0;
    trap_cause = 32'hB; trap_pc = 32'h300; trap_tval = 32'h0;
    trap_req = 1; mret_req = 1;
    pipe_csr_req = 1; pipe_csr_addr = 12'h340; pipe_csr_wdata = 0; pipe_csr_op = 3'b010;
    pipe_csr_we = 0;
    #1;
    if (v_gnt) cyc_g = -1;
    for (int c = 1; c <= 40 && cyc_g == 0; c++) begin
      @(negedge clk);
      #1;
      if (v_tack) begin cyc_t = c; trap_req = 0; end
      if (v_mack) begin
        cyc_m = c; mret_req = 0;
        check("race_mret_pc", v_rpc, 32'h300);
      end
      #1;
      if (v_gnt) cyc_g = c;
    end
    check("race_trap_ack_cycle", cyc_t, 7);
    check("race_mret_ack_cycle", cyc_m, 12);
    check("race_pipe_gnt_cycle", cyc_g, 13);
    @(negedge clk);
    pipe_csr_req = 0; trap_req = 0; mret_req = 0;
    shadow[4] = 32'h300; shadow[5] = 32'hB; shadow[6] = 32'h0; shadow[0] = 32'h1888;
    check("race_mstatus", csr_v[0], 32'h1888);
    check("race_mepc", csr_v[4], 32'h300);

    // Reset asserted while the trap sequence sits in the MCAUSE write
    pipe_rw(12'h342, 32'h11, "rst_pre_mcause");
    pipe_rw(12'h343, 32'h22, "rst_pre_mtval");
    trap_cause = 32'h77; trap_pc = 32'h444; trap_tval = 32'h999; trap_req = 1;
    repeat (3) @(negedge clk);
    rst = 1'b1; trap_req = 0;
    #1;
    check("rst_mid_busy", 32'(v_busy), 32'h0);
    check("rst_mid_redirect", 32'(v_rv), 32'h0);
    check("rst_mid_csr_we", 32'(v_cwe), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    shadow[4] = 32'h444;
    check("rst_mepc_committed", csr_v[4], 32'h444);
    check("rst_mcause_kept", csr_v[5], 32'h11);
    check("rst_mtval_kept", csr_v[6], 32'h22);
    check("rst_after_busy", 32'(v_busy), 32'h0);

    // Randomised mix against the reference model
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          r = $urandom();
          v.is_mret     = 0;
          v.tvec_or_epc = (r & 32'hFFFF_FFFC) |
                          (($urandom_range(0, 1) == 1) ? 32'h1 : 32'($urandom_range(0, 3)));
          v.mstatus     = $urandom();
          v.cause       = ($urandom_range(0, 1) == 1) ? (32'h8000_0000 | 32'($urandom_range(0, 31)))
                                                      : 32'($urandom_range(0, 15));
          v.pc          = $urandom();
          v.tval        = $urandom();
          v.exp_pc_v    = m_target(v.tvec_or_epc, v.cause, 1);
          v.exp_pc_nv   = m_target(v.tvec_or_epc, v.cause, 0);
          v.exp_mstatus = m_trap_ms(v.mstatus);
          v.exp_epc     = v.pc & 32'hFFFF_FFFC;
          run_vec(v, $sformatf("rnd%0d_trap", it));
        end
        1: begin
          v.is_mret     = 1;
          v.tvec_or_epc = $urandom() & 32'hFFFF_FFFC;
          v.mstatus     = $urandom();
          v.cause = 0; v.pc = 0; v.tval = 0;
          v.exp_pc_v    = v.tvec_or_epc;
          v.exp_pc_nv   = v.tvec_or_epc;
          v.exp_mstatus = m_mret_ms(v.mstatus);
          v.exp_epc     = v.tvec_or_epc;
          run_vec(v, $sformatf("rnd%0d_mret", it));
        end
        default: begin
          logic [2:0]  op = ops[$urandom_range(0, 5)];
          logic [11:0] a  = addrs[$urandom_range(0, 9)];
          logic [31:0] wd = op[2] ? 32'($urandom_range(0, 31)) : $urandom();
          logic        we = (op[1:0] == 2'b01) || (wd != 0);
          idx = cidx(a);
          pipe_op(a, wd, op, we, rd, ill);
          check($sformatf("rnd%0d_pipe_ill", it), 32'(ill), (idx < 0) ? 32'h1 : 32'h0);
          if (idx >= 0) begin
            check($sformatf("rnd%0d_pipe_rdata", it), rd, shadow[idx]);
            if (we) shadow[idx] = csr_apply(op, shadow[idx], wd);
            check($sformatf("rnd%0d_pipe_csr", it), csr_v[idx], shadow[idx]);
          end
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
